// File: rtl/trigger_scheduler.sv
// Round-robin trigger scheduler: serializes each granted request as start/tag/parity on Trig.
// Optional parity-error injection (InjErr port) is built when TRIG_ERRINJ_EN is defined.
module trigger_scheduler #(
  parameter int NREQ   = 4,
  parameter int MAXBUF = 4,
  parameter int MINGAP = 1
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic [NREQ-1:0] Req,
  input  logic            Release,
`ifdef TRIG_ERRINJ_EN
  input  logic            InjErr,
`endif
  output logic            Trig,
  output logic [NREQ-1:0] Grant,
  output logic [1:0]      TagOut,
  output logic [3:0]      Credits,
  output logic            Busy,
  output logic [15:0]     NDrop,
  output logic            RelErr
);

  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] MAXC     = 4'(MAXBUF);
  localparam logic [2:0] GAP_LOAD = (MINGAP > 0) ? 3'(MINGAP - 1) : 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_START, S_TB1, S_TB0, S_PAR, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      gap_q, gap_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [1:0]      tag_q, tag_d;
  logic [1:0]      tagout_q, tagout_d;
  logic [3:0]      credits_q, credits_d;
  logic [15:0]     ndrop_q, ndrop_d;
  logic            relerr_q, relerr_d;
  logic            inj_q, inj_d;
  logic            trig_q, trig_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic            eligible, start, rel_ok, inj_set;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [4:0]      drops;
  logic [16:0]     ndrop_sum;

`ifdef TRIG_ERRINJ_EN
  assign inj_set = InjErr;
`else
  assign inj_set = 1'b0;
`endif

  // State register (all sequential state)
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      pend_q    <= '0;
      ptr_q     <= '0;
      tag_q     <= '0;
      tagout_q  <= '0;
      credits_q <= MAXC;
      ndrop_q   <= '0;
      relerr_q  <= 1'b0;
      inj_q     <= 1'b0;
      trig_q    <= 1'b0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      tag_q     <= tag_d;
      tagout_q  <= tagout_d;
      credits_q <= credits_d;
      ndrop_q   <= ndrop_d;
      relerr_q  <= relerr_d;
      inj_q     <= inj_d;
      trig_q    <= trig_d;
      grant_q   <= grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    eligible = (|pend_q) && (credits_q != 4'd0);
    state_d  = state_q;
    gap_d    = gap_q;
    unique case (state_q)
      S_IDLE:  if (eligible) state_d = S_START;
      S_START: state_d = S_TB1;
      S_TB1:   state_d = S_TB0;
      S_TB0:   state_d = S_PAR;
      S_PAR: begin
        if (MINGAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = eligible ? S_START : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 3'd0) state_d = eligible ? S_START : S_IDLE;
        else               gap_d   = gap_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Arbitration: lowest pending index at or above the pointer, else lowest overall
  always_comb begin
    start   = (state_d == S_START);
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (pend_q[i]) win_idx = PW'(i);
    for (int i = NREQ - 1; i >= 0; i--)
      if (pend_q[i] && (PW'(i) >= ptr_q)) win_idx = PW'(i);
    win_oh = '0;
    if (start) win_oh[win_idx] = 1'b1;
  end

  // Datapath next values
  always_comb begin
    ptr_d = ptr_q;
    if (start) ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    drops = '0;
    for (int i = 0; i < NREQ; i++)
      if (Req[i] && pend_q[i] && !win_oh[i]) drops = drops + 5'd1;
    ndrop_sum = {1'b0, ndrop_q} + {12'd0, drops};
    ndrop_d   = ndrop_sum[16] ? 16'hFFFF : ndrop_sum[15:0];
    pend_d    = (pend_q & ~win_oh) | Req;

    rel_ok    = Release && (credits_q != MAXC);
    relerr_d  = relerr_q | (Release && (credits_q == MAXC));
    credits_d = credits_q - {3'd0, start} + {3'd0, rel_ok};

    tag_d    = (state_q == S_PAR) ? tag_q + 2'd1 : tag_q;
    tagout_d = start ? tag_d : tagout_q;
    // The armed error is consumed by the parity bit being launched now
    inj_d    = (inj_q && (state_d != S_PAR)) || inj_set;
  end

  // Output logic: registered line bit and grant for the state being entered
  always_comb begin
    trig_d  = 1'b0;
    grant_d = win_oh;
    unique case (state_d)
      S_START: trig_d = 1'b1;
      S_TB1:   trig_d = tagout_q[1];
      S_TB0:   trig_d = tagout_q[0];
      S_PAR:   trig_d = ~(tagout_q[1] ^ tagout_q[0]) ^ inj_q;
      default: trig_d = 1'b0;
    endcase
  end

  assign Trig    = trig_q;
  assign Grant   = grant_q;
  assign TagOut  = tagout_q;
  assign Credits = credits_q;
  assign Busy    = (state_q != S_IDLE);
  assign NDrop   = ndrop_q;
  assign RelErr  = relerr_q;

endmodule

// File: tb/tb_trigger_scheduler.sv
// Bench for trigger_scheduler: frame scoreboard decoded from Trig, vector table and corner sequences.
// Exercises parity injection only when TRIG_ERRINJ_EN is defined.
module tb_trigger_scheduler;
  localparam int NREQ   = 4;
  localparam int MAXBUF = 4;
  localparam int MINGAP = 1;
  localparam int FR     = 4 + MINGAP;

  logic            Clock = 1'b0;
  logic            ResetN = 1'b0;
  logic [NREQ-1:0] Req = '0;
  logic            Release = 1'b0;
`ifdef TRIG_ERRINJ_EN
  logic            InjErr = 1'b0;
`endif
  logic            Trig;
  logic [NREQ-1:0] Grant;
  logic [1:0]      TagOut;
  logic [3:0]      Credits;
  logic            Busy;
  logic [15:0]     NDrop;
  logic            RelErr;

  trigger_scheduler #(.NREQ(NREQ), .MAXBUF(MAXBUF), .MINGAP(MINGAP)) dut (
    .Clock(Clock), .ResetN(ResetN), .Req(Req), .Release(Release),
`ifdef TRIG_ERRINJ_EN
    .InjErr(InjErr),
`endif
    .Trig(Trig), .Grant(Grant), .TagOut(TagOut), .Credits(Credits),
    .Busy(Busy), .NDrop(NDrop), .RelErr(RelErr)
  );

  always #5 Clock = ~Clock;

  typedef struct {logic [3:0] grant; logic [1:0] tag; logic [3:0] bits;} frame_t;
  typedef struct {logic [3:0] req; logic rel; int nf; logic [3:0] g0; logic [3:0] g1; logic [3:0] cred;} vec_t;

  frame_t sb[$];
  frame_t cur;
  vec_t   vt[5];
  int     starts[$];
  int     total = 0, bad = 0, cyc = 0, mon_ph = 0, exp_tag = 0, acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame bits: start, tag[1], tag[0], odd parity (optionally inverted)
  task automatic push_frame(input logic [3:0] g, input logic inj);
    frame_t f;
    logic [1:0] t;
    t = 2'(exp_tag);
    f.grant = g;
    f.tag   = t;
    f.bits  = {1'b1, t[1], t[0], ~(t[1] ^ t[0]) ^ inj};
    sb.push_back(f);
    exp_tag = (exp_tag + 1) % 4;
  endtask

  // Advance one clock, sample 1 unit after the edge and run the frame monitor
  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
    if (mon_ph == 0) begin
      if (Grant != '0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got grant %b, expected none (cycle %0d)", Grant, cyc);
          cur = '{grant: Grant, tag: TagOut, bits: 4'b1000};
        end else begin
          cur = sb.pop_front();
          chk("grant", int'(Grant), int'(cur.grant));
          chk("tag", int'(TagOut), int'(cur.tag));
        end
        chk("start_bit", int'(Trig), int'(cur.bits[3]));
        starts.push_back(cyc);
        mon_ph = 1;
      end
    end else begin
      chk("grant_idle", int'(Grant), 0);
      chk("trig_bit", int'(Trig), int'(cur.bits[3 - mon_ph]));
      if (mon_ph == 3) begin
        $display("frame grant=%b tag=%0d bits=%b at cycle %0d", cur.grant, cur.tag, cur.bits, cyc);
        mon_ph = 0;
      end else begin
        mon_ph++;
      end
    end
  endtask

  task automatic do_reset();
    ResetN  = 1'b0;
    Req     = '0;
    Release = 1'b0;
`ifdef TRIG_ERRINJ_EN
    InjErr  = 1'b0;
`endif
    mon_ph  = 0;
    sb.delete();
    exp_tag = 0;
    repeat (2) tick();
    ResetN = 1'b1;
  endtask

  initial begin
    vt[0] = '{4'b0001, 1'b0, 1, 4'b0001, 4'b0000, 4'd3};
    vt[1] = '{4'b0100, 1'b0, 1, 4'b0100, 4'b0000, 4'd2};
    vt[2] = '{4'b0010, 1'b1, 1, 4'b0010, 4'b0000, 4'd2};
    vt[3] = '{4'b1000, 1'b1, 1, 4'b1000, 4'b0000, 4'd2};
    vt[4] = '{4'b0011, 1'b0, 2, 4'b0001, 4'b0010, 4'd0};

    do_reset();
    chk("rst_trig", int'(Trig), 0);
    chk("rst_grant", int'(Grant), 0);
    chk("rst_tagout", int'(TagOut), 0);
    chk("rst_credits", int'(Credits), MAXBUF);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_ndrop", int'(NDrop), 0);
    chk("rst_relerr", int'(RelErr), 0);

    // First frame: start bit in the cycle after the request, Busy for FR cycles
    push_frame(4'b0001, 1'b0);
    Req = 4'b0001; tick(); Req = '0;
    chk("first_no_start_yet", int'(Grant), 0);
    tick();
    chk("first_grant", int'(Grant), 1);
    chk("first_credits", int'(Credits), MAXBUF - 1);
    acc = int'(Busy);
    repeat (8) begin tick(); acc += int'(Busy); end
    chk("first_busy_cycles", acc, FR);
    chk("first_sb_empty", sb.size(), 0);

    // Vector table
    do_reset();
    foreach (vt[i]) begin
      push_frame(vt[i].g0, 1'b0);
      if (vt[i].nf > 1) push_frame(vt[i].g1, 1'b0);
      Req = vt[i].req; Release = vt[i].rel; tick(); Req = '0; Release = 1'b0;
      repeat (vt[i].nf * FR + 3) tick();
      chk($sformatf("vec%0d_credits", i), int'(Credits), int'(vt[i].cred));
      chk($sformatf("vec%0d_busy", i), int'(Busy), 0);
      chk($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
    end

    // Burst from all sources: four frames FR cycles apart, credits exhausted
    do_reset();
    starts.delete();
    push_frame(4'b0001, 1'b0); push_frame(4'b0010, 1'b0);
    push_frame(4'b0100, 1'b0); push_frame(4'b1000, 1'b0);
    Req = 4'b1111; tick(); Req = '0;
    repeat (4 * FR + 3) tick();
    chk("burst_frames", starts.size(), 4);
    for (int k = 1; k < starts.size(); k++) chk($sformatf("burst_gap%0d", k), starts[k] - starts[k-1], FR);
    chk("burst_credits", int'(Credits), 0);
    chk("burst_sb_empty", sb.size(), 0);

    // No credits: pending request waits; one Release lets it go on the second edge
    push_frame(4'b0001, 1'b0);
    Req = 4'b0001; tick(); Req = '0;
    acc = 0;
    repeat (8) begin tick(); acc += int'(Trig) + int'(Busy); end
    chk("starved_line_quiet", acc, 0);
    Release = 1'b1; tick(); Release = 1'b0;
    chk("rel_edge1_grant", int'(Grant), 0);
    chk("rel_edge1_credits", int'(Credits), 1);
    tick();
    chk("rel_edge2_grant", int'(Grant), 1);
    chk("rel_edge2_credits", int'(Credits), 0);
    repeat (FR + 2) tick();
    chk("rel_sb_empty", sb.size(), 0);

    // Duplicate request on a pending source is dropped, granted only once
    do_reset();
    push_frame(4'b0001, 1'b0); push_frame(4'b0100, 1'b0);
    Req = 4'b0001; tick();
    Req = 4'b0100; tick();
    Req = 4'b0100; tick();
    Req = '0;
    repeat (3 * FR) tick();
    chk("drop_count", int'(NDrop), 1);
    chk("drop_sb_empty", sb.size(), 0);

    // Release at full credit is ignored and sticky-flagged
    do_reset();
    Release = 1'b1; tick(); Release = 1'b0;
    chk("relerr_credits", int'(Credits), MAXBUF);
    chk("relerr_set", int'(RelErr), 1);
    repeat (3) tick();
    chk("relerr_sticky", int'(RelErr), 1);
`ifdef TRIG_ERRINJ_EN
    InjErr = 1'b1; tick(); InjErr = 1'b0;
    push_frame(4'b0001, 1'b1);
    Req = 4'b0001; tick(); Req = '0;
    repeat (FR + 2) tick();
    push_frame(4'b0010, 1'b0);
    Req = 4'b0010; tick(); Req = '0;
    repeat (FR + 2) tick();
    chk("inj_sb_empty", sb.size(), 0);
`endif
    do_reset();
    chk("relerr_cleared", int'(RelErr), 0);

    // Reset during TB1 of the second frame aborts it and restarts the tag at 0
    push_frame(4'b0001, 1'b0);
    Req = 4'b0001; tick(); Req = '0;
    repeat (FR + 2) tick();
    push_frame(4'b0001, 1'b0);
    Req = 4'b0001; tick(); Req = '0;
    tick();
    tick();
    ResetN = 1'b0; mon_ph = 0; sb.delete(); exp_tag = 0;
    tick();
    chk("midrst_trig", int'(Trig), 0);
    chk("midrst_credits", int'(Credits), MAXBUF);
    chk("midrst_tagout", int'(TagOut), 0);
    chk("midrst_busy", int'(Busy), 0);
    ResetN = 1'b1;
    push_frame(4'b0001, 1'b0);
    Req = 4'b0001; tick(); Req = '0;
    repeat (FR + 2) tick();
    chk("midrst_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
